// File: rtl/fu_pipelined_if.sv
// rtl/fu_pipelined_if.sv - request/result handshake bundle for fu_pipelined
interface fu_pipelined_if #(parameter int WIDTH = 32) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [4:0]       inst;
  logic             ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z;
  logic [3:0]       flags;
  logic             illegal;

  modport master (
    output in_valid, a, b, c, inst, ci, out_ready,
    input  in_ready, out_valid, z, flags, illegal
  );

  modport slave (
    input  in_valid, a, b, c, inst, ci, out_ready,
    output in_ready, out_valid, z, flags, illegal
  );
endinterface

// File: rtl/fu_pipelined.sv
// rtl/fu_pipelined.sv - ALU/shifter/multiply-add unit with one-deep result hold
// and valid/ready handshake on both sides.
module fu_pipelined #(
  parameter int WIDTH       = 32,
  parameter int MADD_STAGES = 2
) (
  input logic          clk,
  input logic          rst_n,
  fu_pipelined_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  localparam int PIPE_N = (MADD_STAGES == 0) ? 1 : MADD_STAGES;
  localparam logic [2:0] CNT_INIT = (MADD_STAGES == 0) ? 3'd0 : 3'(MADD_STAGES - 1);
  localparam logic [SW:0] WBITS = (SW + 1)'(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t           state, state_nxt, launch;
  logic [2:0]       cnt;
  logic [WIDTH-1:0] pipe [PIPE_N];
  logic [WIDTH-1:0] z_q;
  logic [3:0]       flags_q;
  logic             illegal_q;

  logic             in_ready, accept, is_madd;
  logic [1:0]       unit;
  logic [2:0]       sub;
  logic [SW-1:0]    sh;
  logic [SW:0]      rol_amt;
  logic [WIDTH-1:0] op_b, madd_comb, madd_out, res_z;
  logic [WIDTH:0]   sum, sll_ext, srl_ext, sra_ext;
  logic             cin, res_c, res_v, res_ill;
  logic [3:0]       res_flags;

  assign unit      = bus.inst[4:3];
  assign sub       = bus.inst[2:0];
  assign is_madd   = (unit == 2'b10);
  assign sh        = bus.b[SW-1:0];
  assign in_ready  = rst_n && ((state == IDLE) || ((state == HOLD) && bus.out_ready));
  assign accept    = bus.in_valid && in_ready;
  assign madd_out  = pipe[PIPE_N-1];

  // Sub-ops 0..3 share one adder: bit1 inverts B, carry-in is CI for odd sub-ops.
  assign op_b      = sub[1] ? ~bus.b : bus.b;
  assign cin       = sub[0] ? bus.ci : sub[1];
  assign sum       = {1'b0, bus.a} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
  assign madd_comb = bus.a * bus.b + bus.c;

  // Shifts run one bit wider so the last bit shifted out lands in the spare bit.
  assign sll_ext   = {1'b0, bus.a} << sh;
  assign srl_ext   = {bus.a, 1'b0} >> sh;
  assign sra_ext   = $signed({bus.a, 1'b0}) >>> sh;
  assign rol_amt   = WBITS - {1'b0, sh};

  always_comb begin
    res_z   = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    res_ill = 1'b0;
    case (unit)
      2'b00: begin
        case (sub)
          3'd4:    res_z = bus.a & bus.b;
          3'd5:    res_z = bus.a | bus.b;
          3'd6:    res_z = bus.a ^ bus.b;
          3'd7:    res_z = ~bus.a;
          default: begin
            res_z = sum[WIDTH-1:0];
            res_c = sum[WIDTH];
            res_v = (bus.a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
          end
        endcase
      end
      2'b01: begin
        case (sub)
          3'd0: begin res_z = sll_ext[WIDTH-1:0]; res_c = sll_ext[WIDTH]; end
          3'd1: begin res_z = srl_ext[WIDTH:1];   res_c = srl_ext[0];     end
          3'd2: begin res_z = sra_ext[WIDTH:1];   res_c = sra_ext[0];     end
          3'd3:    res_z = (bus.a << sh) | (bus.a >> rol_amt);
          default: res_ill = 1'b1;
        endcase
      end
      2'b10:   res_z = madd_comb;
      default: res_ill = 1'b1;
    endcase
    res_flags = res_ill ? 4'b0000 : {res_z[WIDTH-1], (res_z == '0), res_c, res_v};
  end

  always_comb begin
    launch    = (is_madd && (MADD_STAGES != 0)) ? CALC : HOLD;
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = launch;
      CALC:    if (cnt == 3'd0) state_nxt = HOLD;
      HOLD:    if (bus.out_ready) state_nxt = accept ? launch : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      z_q       <= '0;
      flags_q   <= 4'b0000;
      illegal_q <= 1'b0;
      for (int i = 0; i < PIPE_N; i++) pipe[i] <= '0;
    end else begin
      state     <= state_nxt;
      illegal_q <= accept && res_ill;
      if (accept && is_madd) pipe[0] <= madd_comb;
      for (int i = 1; i < PIPE_N; i++) pipe[i] <= pipe[i-1];
      if (accept) begin
        if (is_madd && (MADD_STAGES != 0)) begin
          cnt <= CNT_INIT;
        end else begin
          z_q     <= res_z;
          flags_q <= res_flags;
        end
      end else if (state == CALC) begin
        if (cnt == 3'd0) begin
          z_q     <= madd_out;
          flags_q <= {madd_out[WIDTH-1], (madd_out == '0), 2'b00};
        end else begin
          cnt <= cnt - 3'd1;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == HOLD);
  assign bus.z         = z_q;
  assign bus.flags     = flags_q;
  assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_fu_pipelined.sv
// tb/tb_fu_pipelined.sv - directed self-checking bench for fu_pipelined
module tb_fu_pipelined;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  fu_pipelined_if #(.WIDTH(32)) bus ();

  fu_pipelined #(.WIDTH(32), .MADD_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic req(input logic [4:0] inst, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] c, input logic ci);
    bus.in_valid = 1'b1;
    bus.inst     = inst;
    bus.a        = a;
    bus.b        = b;
    bus.c        = c;
    bus.ci       = ci;
  endtask

  task automatic result(input string tag, input logic [31:0] z, input logic [3:0] flags);
    check({tag, "_valid"}, bus.out_valid, 1'b1);
    check({tag, "_z"}, bus.z, z);
    check({tag, "_flags"}, bus.flags, flags);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    req(5'b00000, 32'd0, 32'd0, 32'd0, 1'b0);
    bus.in_valid  = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_z", bus.z, 32'd0);
    check("rst_flags", bus.flags, 4'b0000);
    check("rst_illegal", bus.illegal, 1'b0);
    step();
    step();

    // First edge after release accepts ADD 0x7FFFFFFF + 1
    req(5'b00000, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0);
    rst_n = 1'b1;
    #1;
    check("first_in_ready", bus.in_ready, 1'b1);
    step();
    result("add_ovf", 32'h8000_0000, 4'b1001);
    check("add_ovf_illegal", bus.illegal, 1'b0);

    // Back-to-back ALU/shift ops while out_ready=1
    req(5'b00010, 32'd5, 32'd5, 32'd0, 1'b0);
    check("hold_in_ready", bus.in_ready, 1'b1);
    step(); result("sub_eq", 32'd0, 4'b0110);
    req(5'b01010, 32'h8000_0000, 32'd4, 32'd0, 1'b0);
    step(); result("sra", 32'hF800_0000, 4'b1000);
    req(5'b01000, 32'h8000_0001, 32'h0000_0021, 32'd0, 1'b0);
    step(); result("sll_c", 32'h0000_0002, 4'b0010);
    req(5'b01001, 32'h0000_0018, 32'd4, 32'd0, 1'b0);
    step(); result("srl_c", 32'h0000_0001, 4'b0010);
    req(5'b01011, 32'h8000_0001, 32'd4, 32'd0, 1'b0);
    step(); result("rol", 32'h0000_0018, 4'b0000);
    req(5'b00011, 32'd3, 32'd5, 32'd0, 1'b0);
    step(); result("sbb", 32'hFFFF_FFFD, 4'b1000);
    req(5'b00001, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1);
    step(); result("adc", 32'd0, 4'b0110);
    req(5'b00110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 1'b0);
    step(); result("xor", 32'h0FF0_0FF0, 4'b0000);
    req(5'b00111, 32'd0, 32'd0, 32'd0, 1'b0);
    step(); result("not", 32'hFFFF_FFFF, 4'b1000);
    bus.in_valid = 1'b0;
    step();
    check("idle_valid", bus.out_valid, 1'b0);

    // MADD latency 3, requests during CALC are ignored
    req(5'b10000, 32'hFFFF_FFFF, 32'd2, 32'd3, 1'b0);
    step();
    req(5'b00100, 32'hF, 32'hF, 32'd0, 1'b0);
    check("calc1_valid", bus.out_valid, 1'b0);
    check("calc1_in_ready", bus.in_ready, 1'b0);
    step();
    check("calc2_valid", bus.out_valid, 1'b0);
    check("calc2_in_ready", bus.in_ready, 1'b0);
    bus.out_ready = 1'b0;
    req(5'b00000, 32'd2, 32'd3, 32'd0, 1'b0);
    step();
    result("madd", 32'h0000_0001, 4'b0000);

    // Back-pressure for 5 cycles, then ADD accepted on the releasing edge
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", bus.in_ready, 1'b0);
      step();
      result("bp_hold", 32'h0000_0001, 4'b0000);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", bus.in_ready, 1'b1);
    step();
    result("bp_add", 32'd5, 4'b0000);

    // Reserved unit select
    req(5'b11000, 32'd5, 32'd5, 32'd0, 1'b0);
    step();
    result("rsv", 32'd0, 4'b0000);
    check("rsv_illegal", bus.illegal, 1'b1);
    bus.in_valid = 1'b0;
    step();
    check("rsv_done_valid", bus.out_valid, 1'b0);
    check("rsv_done_illegal", bus.illegal, 1'b0);

    // Reserved shift sub-op under stall: ILLEGAL only on the first HOLD cycle
    req(5'b01100, 32'h1234, 32'd1, 32'd0, 1'b0);
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    result("rsv_sh", 32'd0, 4'b0000);
    check("rsv_sh_illegal", bus.illegal, 1'b1);
    step();
    check("rsv_sh_stall_valid", bus.out_valid, 1'b1);
    check("rsv_sh_stall_illegal", bus.illegal, 1'b0);
    bus.out_ready = 1'b1;
    step();

    // Reset in the middle of CALC aborts the MADD
    req(5'b00000, 32'd7, 32'd8, 32'd0, 1'b0);
    step();
    check("pre_abort_z", bus.z, 32'd15);
    req(5'b10000, 32'd3, 32'd4, 32'd5, 1'b0);
    step();
    bus.in_valid = 1'b0;
    check("abort_calc_valid", bus.out_valid, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_z", bus.z, 32'd0);
    check("abort_flags", bus.flags, 4'b0000);
    check("abort_in_ready", bus.in_ready, 1'b0);
    check("abort_valid", bus.out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("abort_no_late_valid", bus.out_valid, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
